// File: rtl/pe_bus_responder.sv
// Bus-side responder for one processing element: owns its register file and word-addressed data memory,
// answers operand reads, loads/stores and register writeback with a four-phase request/release handshake.
module pe_bus_responder #(
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic [4:0]        rs1Out,
    input  logic [4:0]        rs2Out,
    input  logic [4:0]        rdOut,
    input  logic              rdWrite,
    input  logic              reg_select,
    input  logic [DATA_W-1:0] result_out,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    output logic [DATA_W-1:0] AmuxIn,
    output logic [DATA_W-1:0] BmuxIn,
    output logic              data_Ready,
    output logic              mem_ack,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_DONE,
        MEM_WAIT,
        MEM_ACK,
        WAIT_REL
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [DATA_W-1:0] r_regs [32];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];

    logic [DATA_W-1:0] r_ldbuf;
    logic [DATA_W-1:0] r_amux;
    logic [DATA_W-1:0] r_bmux;
    logic [DATA_W-1:0] r_wdata;
    logic [AW-1:0]     r_idx;
    logic              r_is_store;
    logic              r_fault;
    logic [CW-1:0]     r_cnt;

    logic              w_mem_req;
    logic              w_fault;
    logic              w_wb_en;
    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_load_data;
    logic              w_accept_rd;
    logic              w_accept_mem;
    logic              w_ack;
    logic              w_ld_done;

    assign w_mem_req = mem_read | mem_write;
    // Misaligned, or any address bit above the memory's word range set.
    assign w_fault   = (|mem_address[1:0]) | (|mem_address[31:AW+2]);
    assign w_wb_en   = rdWrite && (rdOut != 5'd0);
    assign w_wb_data = reg_select ? r_ldbuf : result_out;

    // Operand read with same-cycle writeback bypass; x0 is hard-wired to zero.
    always_comb begin
        w_rs1_data = r_regs[rs1Out];
        w_rs2_data = r_regs[rs2Out];
        if (w_wb_en && (rdOut == rs1Out)) w_rs1_data = w_wb_data;
        if (w_wb_en && (rdOut == rs2Out)) w_rs2_data = w_wb_data;
        if (rs1Out == 5'd0) w_rs1_data = '0;
        if (rs2Out == 5'd0) w_rs2_data = '0;
    end

    assign w_load_data  = r_fault ? '0 : r_mem[r_idx];
    assign w_accept_mem = (r_state == IDLE) && w_mem_req;
    assign w_accept_rd  = (r_state == IDLE) && read_en && !w_mem_req;
    assign w_ack        = (r_state == MEM_ACK);
    assign w_ld_done    = w_ack && !r_is_store;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: begin
                if (w_mem_req)    w_state_n = (MEM_LATENCY == 0) ? MEM_ACK : MEM_WAIT;
                else if (read_en) w_state_n = RD_DONE;
            end
            RD_DONE:  w_state_n = WAIT_REL;
            MEM_WAIT: if (r_cnt == LAT_LAST) w_state_n = MEM_ACK;
            MEM_ACK:  w_state_n = WAIT_REL;
            WAIT_REL: if (!(read_en || mem_read || mem_write)) w_state_n = IDLE;
            default:  w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_ldbuf    <= '0;
            r_amux     <= '0;
            r_bmux     <= '0;
            r_wdata    <= '0;
            r_idx      <= '0;
            r_is_store <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_wb_en) r_regs[rdOut] <= w_wb_data;
            if (w_accept_mem) begin
                r_idx      <= mem_address[AW+1:2];
                r_is_store <= mem_write;
                r_fault    <= w_fault;
                r_wdata    <= result_out;
                r_cnt      <= '0;
            end
            if (r_state == MEM_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_accept_rd) begin
                r_amux <= w_rs1_data;
                r_bmux <= w_rs2_data;
            end
            // Capture the load result so AmuxIn holds it after the ack cycle.
            if (w_ld_done) begin
                r_amux  <= w_load_data;
                r_ldbuf <= w_load_data;
            end
        end
    end

    // Memory is not cleared by reset; a reset in the ack cycle suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && w_ack && r_is_store && !r_fault) r_mem[r_idx] <= r_wdata;
    end

    assign AmuxIn     = w_ld_done ? w_load_data : r_amux;
    assign BmuxIn     = r_bmux;
    assign data_Ready = (r_state == RD_DONE) || w_ld_done;
    assign mem_ack    = w_ack;
    assign err        = w_ack && r_fault;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_pe_bus_responder.sv
// Directed bench for pe_bus_responder: operand reads, writeback, loads/stores, faults, handshake and reset abort.
module tb_pe_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_en;
    logic [4:0]  rs1Out, rs2Out, rdOut;
    logic        rdWrite, reg_select;
    logic [31:0] result_out;
    logic        mem_read, mem_write;
    logic [31:0] mem_address;
    logic [31:0] AmuxIn, BmuxIn;
    logic        data_Ready, mem_ack, busy, err;

    int n_vec = 0;
    int n_bad = 0;

    pe_bus_responder #(.DATA_W(32), .MEM_DEPTH(256), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .read_en(read_en), .rs1Out(rs1Out), .rs2Out(rs2Out),
        .rdOut(rdOut), .rdWrite(rdWrite), .reg_select(reg_select), .result_out(result_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .AmuxIn(AmuxIn), .BmuxIn(BmuxIn), .data_Ready(data_Ready), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 10 && busy; i++) tick();
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Operand read: returns what was presented in the data_Ready cycle.
    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           output logic [31:0] ra, output logic [31:0] rb, output logic rdy);
        read_en = 1'b1; rs1Out = a; rs2Out = b;
        tick();
        ra = AmuxIn; rb = BmuxIn; rdy = data_Ready;
        read_en = 1'b0;
        tick();
        wait_idle("rd_release");
    endtask

    // Memory op held until ack; reports latency and the ack-cycle outputs.
    task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] ra, output logic e, output logic rdy);
        mem_write = wr; mem_read = ~wr; mem_address = addr; result_out = data;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (mem_ack) break;
        end
        ra = AmuxIn; e = err; rdy = data_Ready;
        mem_write = 1'b0; mem_read = 1'b0;
        tick();
        wait_idle("mem_release");
    endtask

    task automatic wb(input logic [4:0] rd, input logic sel, input logic [31:0] data);
        rdWrite = 1'b1; rdOut = rd; reg_select = sel; result_out = data;
        tick();
        rdWrite = 1'b0; reg_select = 1'b0;
    endtask

    logic [31:0] a, b;
    logic        e, rdy;
    int          lat, acks, rdys;

    initial begin
        reset = 1'b1; read_en = 1'b0; rs1Out = '0; rs2Out = '0; rdOut = '0;
        rdWrite = 1'b0; reg_select = 1'b0; result_out = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_amux", AmuxIn, 32'd0);
        chk("rst_bmux", BmuxIn, 32'd0);
        chk("rst_flags", {28'd0, data_Ready, mem_ack, busy, err}, 32'd0);

        // First operand read after reset
        read_en = 1'b1; rs1Out = 5'd3; rs2Out = 5'd0;
        tick();
        chk("rd0_ready", {31'd0, data_Ready}, 32'd1);
        chk("rd0_busy", {31'd0, busy}, 32'd1);
        chk("rd0_a", AmuxIn, 32'd0);
        chk("rd0_b", BmuxIn, 32'd0);
        read_en = 1'b0;
        tick();
        chk("rd0_ready_pulse", {31'd0, data_Ready}, 32'd0);
        tick();
        chk("rd0_busy_drop", {31'd0, busy}, 32'd0);

        // Writeback and x0
        wb(5'd5, 1'b0, 32'hDEADBEEF);
        do_read(5'd5, 5'd5, a, b, rdy);
        chk("wb_r5_a", a, 32'hDEADBEEF);
        chk("wb_r5_b", b, 32'hDEADBEEF);
        wb(5'd0, 1'b0, 32'h1234);
        do_read(5'd0, 5'd0, a, b, rdy);
        chk("x0_a", a, 32'd0);

        // Store then load
        do_mem(1'b1, 32'h40, 32'hCAFEF00D, lat, a, e, rdy);
        chk("st_lat", lat, 32'd3);
        chk("st_err", {31'd0, e}, 32'd0);
        chk("st_noready", {31'd0, rdy}, 32'd0);
        do_mem(1'b0, 32'h40, 32'h0, lat, a, e, rdy);
        chk("ld_lat", lat, 32'd3);
        chk("ld_data", a, 32'hCAFEF00D);
        chk("ld_ready", {31'd0, rdy}, 32'd1);
        chk("ld_hold", AmuxIn, 32'hCAFEF00D);
        wb(5'd7, 1'b1, 32'h0);
        do_read(5'd7, 5'd5, a, b, rdy);
        chk("ldbuf_r7", a, 32'hCAFEF00D);

        // Faults
        do_mem(1'b1, 32'h41, 32'h11111111, lat, a, e, rdy);
        chk("mis_st_lat", lat, 32'd3);
        chk("mis_st_err", {31'd0, e}, 32'd1);
        do_mem(1'b0, 32'h40, 32'h0, lat, a, e, rdy);
        chk("mis_st_nowrite", a, 32'hCAFEF00D);
        do_mem(1'b0, 32'h400, 32'h0, lat, a, e, rdy);
        chk("oob_ld_err", {31'd0, e}, 32'd1);
        chk("oob_ld_data", a, 32'd0);
        wb(5'd8, 1'b1, 32'hFFFFFFFF);
        do_read(5'd8, 5'd0, a, b, rdy);
        chk("oob_ldbuf", a, 32'd0);

        // Level-held load: one ack only
        mem_read = 1'b1; mem_address = 32'h40; acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_ack) acks++;
        end
        mem_read = 1'b0;
        tick();
        wait_idle("held_release");
        chk("held_acks", acks, 32'd1);

        // Store wins over a simultaneous operand read
        read_en = 1'b1; rs1Out = 5'd5; mem_write = 1'b1; mem_address = 32'h44; result_out = 32'hA5A5;
        acks = 0; rdys = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ack) acks++;
            if (data_Ready) rdys++;
        end
        read_en = 1'b0; mem_write = 1'b0;
        tick();
        wait_idle("prio_release");
        chk("prio_acks", acks, 32'd1);
        chk("prio_noready", rdys, 32'd0);
        do_mem(1'b0, 32'h44, 32'h0, lat, a, e, rdy);
        chk("prio_stored", a, 32'hA5A5);

        // read_en pulse during MEM_WAIT is ignored
        mem_read = 1'b1; mem_address = 32'h40; rdys = 0;
        tick();
        read_en = 1'b1; rs1Out = 5'd5;
        tick();
        if (data_Ready) rdys++;
        read_en = 1'b0;
        tick();
        chk("ignore_ack", {31'd0, mem_ack}, 32'd1);
        chk("ignore_data", AmuxIn, 32'hCAFEF00D);
        mem_read = 1'b0;
        tick();
        if (data_Ready) rdys++;
        tick();
        if (data_Ready) rdys++;
        wait_idle("ignore_release");
        chk("ignore_noready", rdys, 32'd0);

        // Same-cycle writeback bypass
        read_en = 1'b1; rs1Out = 5'd9; rs2Out = 5'd5;
        rdWrite = 1'b1; rdOut = 5'd9; result_out = 32'h55;
        tick();
        rdWrite = 1'b0;
        chk("bypass_a", AmuxIn, 32'h55);
        chk("bypass_b", BmuxIn, 32'hDEADBEEF);
        read_en = 1'b0;
        tick();
        wait_idle("bypass_release");

        // Reset during MEM_WAIT of a store aborts it
        do_mem(1'b1, 32'h80, 32'h77, lat, a, e, rdy);
        mem_write = 1'b1; mem_address = 32'h80; result_out = 32'h12345678;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_write = 1'b0;
        chk("abort_idle", {30'd0, busy, mem_ack}, 32'd0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_ack) acks++;
        end
        chk("abort_noack", acks, 32'd0);
        do_read(5'd5, 5'd9, a, b, rdy);
        chk("abort_r5", a, 32'd0);
        chk("abort_r9", b, 32'd0);
        do_mem(1'b0, 32'h80, 32'h0, lat, a, e, rdy);
        chk("abort_mem", a, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
